// File: rtl/dnn_sample_feeder.sv
// -----------------------------------------------------------------------------
// dnn_sample_feeder
//
// Streaming sample loader placed between the training-data source and the DNN
// top level. One training sample arrives as C activation chunks (plus label
// and etapos on the first beat) over a valid/ready handshake. It lands in a
// ping-pong buffer. The sample is then replayed into act0/ans0/etapos0 in
// lock-step with the network's cycle_index. When no complete sample is ready
// at a block boundary, a zero-learning-rate bubble is emitted instead.
//
// Ports:
//   clk            sole clock
//   reset          asynchronous, active-low reset
//   cycle_index    DNN cycle counter, 0..cpc-1, boundary at cpc-1
//   in_valid       source beat valid
//   in_ready       feeder can accept a beat
//   in_data        one activation chunk, LSB = lowest neuron of the chunk
//   in_label       correct class, taken from beat 0 only
//   in_etapos      sample learning-rate exponent, taken from beat 0 only
//   act0           activation chunk to the DNN
//   ans0           one-hot slice of the label for this cycle
//   etapos0        learning-rate exponent to the DNN (0 = no update)
//   sample_active  high while a real sample is playing
//   underrun_count saturating count of idle blocks
//                  (present only when FEEDER_UNDERRUN_CNT_EN is defined)
//
// Optional feature macro: FEEDER_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
module dnn_sample_feeder #(
  parameter int width_in = 8,
  parameter int n0       = 1024,
  parameter int fo0      = 8,
  parameter int z0       = 512,
  parameter int nL       = 16,
  parameter int zbyfiL   = 1,
  parameter int etapos_w = 4,
  localparam int C       = n0 * fo0 / z0,
  localparam int cpc     = C + 2,
  localparam int dw      = width_in * z0 / fo0,
  localparam int ciw     = $clog2(cpc),
  localparam int lw      = (nL > 1) ? $clog2(nL) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ciw-1:0]      cycle_index,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [dw-1:0]       in_data,
  input  logic [lw-1:0]       in_label,
  input  logic [etapos_w-1:0] in_etapos,
  output logic [dw-1:0]       act0,
  output logic [zbyfiL-1:0]   ans0,
  output logic [etapos_w-1:0] etapos0,
  output logic                sample_active
`ifdef FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_count
`endif
);

  localparam int iw = (C > 1) ? $clog2(C) : 1;
  localparam logic [iw-1:0]  last_idx     = iw'(C - 1);
  localparam logic [ciw-1:0] last_cycle   = ciw'(cpc - 1);
  localparam logic [ciw-1:0] chunk_cycles = ciw'(C);

  // The output layer must be walked in exactly one chunk per cycle.
  if (nL / zbyfiL != C) begin : g_bad_cfg
    $error("dnn_sample_feeder: nL/zbyfiL must equal n0*fo0/z0");
  end

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state, state_next;
  logic [dw-1:0]       chunk_mem  [2][C];
  logic [lw-1:0]       label_mem  [2];
  logic [etapos_w-1:0] etapos_mem [2];
  logic [1:0]          full;
  logic                wr_bank;
  logic [iw-1:0]       wr_idx;
  logic                cur_bank;
  logic                next_bank;
  logic                take_bank;
  logic                accept;
  logic                last_beat;
  logic                boundary;
  logic                release_bank;

  // in_ready is held low combinationally while reset is asserted.
  assign in_ready     = reset && !full[wr_bank];
  assign accept       = in_valid && in_ready;
  assign last_beat    = accept && (wr_idx == last_idx);
  assign boundary     = (cycle_index == last_cycle);
  assign release_bank = boundary && (state == PLAY);

  // Write pointers: fill one bank chunk by chunk, then move to the other bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (accept) begin
      if (wr_idx == last_idx) begin
        wr_idx  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  // Sample storage. Contents need no reset: a bank is only read once its
  // full flag says every chunk has been written since the last reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      chunk_mem[wr_bank][wr_idx] <= in_data;
      if (wr_idx == '0) begin
        label_mem[wr_bank]  <= in_label;
        etapos_mem[wr_bank] <= in_etapos;
      end
    end
  end

  // Full flags. The bank being released and the bank being completed are
  // always different, so both updates can happen on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= '0;
    end else begin
      if (release_bank) full[cur_bank] <= 1'b0;
      if (last_beat)    full[wr_bank]  <= 1'b1;
    end
  end

  // Play-side state register and bank selection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_bank  <= 1'b0;
      next_bank <= 1'b0;
    end else begin
      state <= state_next;
      if (take_bank) begin
        cur_bank  <= next_bank;
        next_bank <= ~next_bank;
      end
    end
  end

  // Next-state decision, taken only at a block boundary. The full flag is the
  // registered value, so a bank completing on this very edge waits a block.
  always_comb begin
    state_next = state;
    take_bank  = 1'b0;
    if (boundary) begin
      if (full[next_bank]) begin
        state_next = PLAY;
        take_bank  = 1'b1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Playback outputs. The last two cycles of a block carry no activations
  // but keep etapos so the backward pass still sees the learning rate.
  always_comb begin
    act0          = '0;
    ans0          = '0;
    etapos0       = '0;
    sample_active = 1'b0;
    if (state == PLAY) begin
      sample_active = 1'b1;
      etapos0       = etapos_mem[cur_bank];
      if (cycle_index < chunk_cycles) begin
        act0 = chunk_mem[cur_bank][cycle_index[iw-1:0]];
        for (int j = 0; j < zbyfiL; j++) begin
          ans0[j] = (int'(label_mem[cur_bank]) == int'(cycle_index) * zbyfiL + j);
        end
      end
    end
  end

`ifdef FEEDER_UNDERRUN_CNT_EN
  // Count every boundary that falls back to a bubble, saturating at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_count <= '0;
    end else if (boundary && !full[next_bank] && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dnn_sample_feeder.sv
// -----------------------------------------------------------------------------
// tb_dnn_sample_feeder
//
// Self-checking bench for dnn_sample_feeder with default parameters
// (C = 16 chunks, cpc = 18, 512-bit chunks, 16 classes). The bench models the
// DNN cycle counter, loads samples and pushes each completed sample onto a
// scoreboard queue; a monitor pops a sample whenever a playback block starts
// and checks every cycle of it. Scenario tasks add timing-specific checks.
// Optional feature macro: FEEDER_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
module tb_dnn_sample_feeder;

  localparam int C   = 16;
  localparam int CPC = 18;
  localparam int DW  = 512;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    cycle_index = 5'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    in_label = 4'd0;
  logic [3:0]    in_etapos = 4'd0;
  logic [DW-1:0] act0;
  logic [0:0]    ans0;
  logic [3:0]    etapos0;
  logic          sample_active;
`ifdef FEEDER_UNDERRUN_CNT_EN
  logic [15:0]   underrun_count;
`endif

  typedef struct {
    int seed;
    int label;
    int etapos;
  } sample_t;

  sample_t sb[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  bit      mon_in_block = 1'b0;

  dnn_sample_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .cycle_index   (cycle_index),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_label      (in_label),
    .in_etapos     (in_etapos),
    .act0          (act0),
    .ans0          (ans0),
    .etapos0       (etapos0),
    .sample_active (sample_active)
`ifdef FEEDER_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  // Model of the DNN cycle counter, free running 0..CPC-1.
  initial begin : dnn_cycle_counter
    forever begin
      @(posedge clk);
      #1;
      cycle_index = (cycle_index == 5'(CPC - 1)) ? 5'd0 : cycle_index + 5'd1;
    end
  end

  // Global watchdog.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Byte b of chunk k of sample 'seed'; seed 0 gives {64{8'(k)}}.
  function automatic logic [DW-1:0] make_chunk(input int seed, input int k);
    logic [DW-1:0] c;
    c = '0;
    for (int b = 0; b < DW / 8; b++) c[b*8 +: 8] = 8'(k + seed * b);
    return c;
  endfunction

  // Scoreboard monitor: at each block start pop the expected sample if the
  // DUT announces playback, then check every output on every cycle.
  initial begin : scoreboard_monitor
    sample_t       cur;
    int            ci;
    logic [DW-1:0] exp_act;
    logic [0:0]    exp_ans;
    logic [3:0]    exp_eta;
    logic          exp_sa;
    cur = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_in_block = 1'b0;
        n_cmp++;
        if ({act0, ans0, etapos0, sample_active, in_ready} !== '0) begin
          n_bad++;
          $display("FAIL reset_outputs t=%0t: act0|ans0|etapos0|active|ready not all zero (ans0=%b eta=%0d act=%0b rdy=%0b), required 0",
                   $time, ans0, etapos0, sample_active, in_ready);
        end
      end else begin
        ci = int'(cycle_index);
        if (ci == 0) begin
          if (sample_active) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL sb_unexpected_play t=%0t: sample_active=1 with no loaded sample, required 0", $time);
              mon_in_block = 1'b0;
            end else begin
              cur = sb.pop_front();
              mon_in_block = 1'b1;
            end
          end else begin
            mon_in_block = 1'b0;
          end
        end
        if (mon_in_block) begin
          exp_act = (ci < C) ? make_chunk(cur.seed, ci) : '0;
          exp_ans = 1'((ci < C) && (cur.label == ci));
          exp_eta = 4'(cur.etapos);
          exp_sa  = 1'b1;
        end else begin
          exp_act = '0;
          exp_ans = 1'b0;
          exp_eta = 4'd0;
          exp_sa  = 1'b0;
        end
        n_cmp++;
        if (sample_active !== exp_sa) begin
          n_bad++;
          $display("FAIL sb_active ci=%0d: got %0b, required %0b", ci, sample_active, exp_sa);
        end
        n_cmp++;
        if (act0 !== exp_act) begin
          n_bad++;
          $display("FAIL sb_act0 seed=%0d ci=%0d: got %h, required %h", cur.seed, ci, act0, exp_act);
        end
        n_cmp++;
        if (ans0 !== exp_ans) begin
          n_bad++;
          $display("FAIL sb_ans0 label=%0d ci=%0d: got %b, required %b", cur.label, ci, ans0, exp_ans);
        end
        n_cmp++;
        if (etapos0 !== exp_eta) begin
          n_bad++;
          $display("FAIL sb_etapos0 ci=%0d: got %0d, required %0d", ci, etapos0, exp_eta);
        end
      end
    end
  end

  // Advance to just after a rising edge (after the cycle counter updates).
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Stop just after the edge so that the next accepted beat lands at ci = v.
  task automatic align_to(input int v);
    int g;
    g = 0;
    do begin
      step();
      g++;
    end while (int'(cycle_index) != v && g < 40);
  endtask

  // Advance at least one falling edge, stopping where cycle_index == v.
  task automatic wait_neg_ci(input int v);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (int'(cycle_index) != v && g < 40);
  endtask

  // Drive up to stop_after beats of a sample; later beats carry random label
  // and etapos. A completed sample is pushed onto the scoreboard on the edge
  // that accepts its last beat.
  task automatic send_sample(input int seed, input int label, input int etapos,
                             input int stall_pct, input int stop_after);
    int k;
    int waited;
    bit rdy;
    k = 0;
    waited = 0;
    while (k < stop_after) begin
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_data   = make_chunk(seed, k);
        in_label  = (k == 0) ? 4'(label) : 4'($urandom);
        in_etapos = (k == 0) ? 4'(etapos) : 4'($urandom);
      end
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) begin
        if (k == C - 1) sb.push_back('{seed, label, etapos});
        k++;
        waited = 0;
      end else if (in_valid) begin
        waited++;
        if (waited > 100) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout seed=%0d beat=%0d: in_ready stayed 0, required 1 within 100 clocks", seed, k);
          #2;
          break;
        end
      end
      #2;
    end
    in_valid = 1'b0;
  endtask

  // Wait until every loaded sample has finished playing.
  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || mon_in_block) && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    n_cmp++;
    if (sb.size() != 0 || mon_in_block) begin
      n_bad++;
      $display("FAIL drain: %0d samples still unplayed after 200 clocks, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || sample_active !== 1'b0 || etapos0 !== 4'd0 || act0 !== '0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%0b active=%0b eta=%0d, required all 0", in_ready, sample_active, etapos0);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_single_sample();
    int active_cycles;
    $display("[TB] single sample");
    align_to(0);
    send_sample(0, 5, 3, 0, C);
    wait_neg_ci(0);
    n_cmp++;
    if (sample_active !== 1'b1 || etapos0 !== 4'd3) begin
      n_bad++;
      $display("FAIL single_start: active=%0b eta=%0d, required 1 and 3", sample_active, etapos0);
    end
    active_cycles = 0;
    for (int c = 0; c < CPC; c++) begin
      if (sample_active && etapos0 == 4'd3) active_cycles++;
      if (c < CPC - 1) @(negedge clk);
    end
    n_cmp++;
    if (active_cycles != CPC) begin
      n_bad++;
      $display("FAIL single_length: etapos0=3 for %0d clocks, required %0d", active_cycles, CPC);
    end
    @(negedge clk);
    n_cmp++;
    if (sample_active !== 1'b0 || etapos0 !== 4'd0) begin
      n_bad++;
      $display("FAIL single_end_idle: active=%0b eta=%0d, required 0 and 0", sample_active, etapos0);
    end
    drain();
  endtask

  task automatic test_underrun();
    bit bad;
`ifdef FEEDER_UNDERRUN_CNT_EN
    logic [15:0] u0;
`endif
    $display("[TB] underrun");
    wait_neg_ci(0);
`ifdef FEEDER_UNDERRUN_CNT_EN
    u0 = underrun_count;
`endif
    for (int b = 0; b < 3; b++) begin
      bad = 1'b0;
      for (int c = 0; c < CPC; c++) begin
        if (sample_active !== 1'b0 || etapos0 !== 4'd0) bad = 1'b1;
        @(negedge clk);
      end
      n_cmp++;
      if (bad) begin
        n_bad++;
        $display("FAIL underrun_block%0d: active or etapos0 nonzero during bubble, required 0", b);
      end
    end
`ifdef FEEDER_UNDERRUN_CNT_EN
    n_cmp++;
    if (underrun_count - u0 !== 16'd3) begin
      n_bad++;
      $display("FAIL underrun_count: increased by %0d, required 3", underrun_count - u0);
    end
`endif
  endtask

  task automatic test_boundary_race();
    $display("[TB] boundary race");
    align_to(2);
    send_sample(9, 15, 6, 0, C);
    wait_neg_ci(0);
    n_cmp++;
    if (sample_active !== 1'b0) begin
      n_bad++;
      $display("FAIL race_first_block: active=%0b, required 0", sample_active);
    end
    wait_neg_ci(0);
    n_cmp++;
    if (sample_active !== 1'b1) begin
      n_bad++;
      $display("FAIL race_second_block: active=%0b, required 1", sample_active);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    $display("[TB] back to back");
    align_to(0);
    fork
      begin
        send_sample(1, 0, 2, 0, C);
        send_sample(2, 7, 4, 0, C);
        send_sample(3, 12, 1, 0, C);
      end
      begin
        wait_neg_ci(1);
        wait_neg_ci(0);
        n_cmp++;
        if (sample_active !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_block1: active=%0b, required 1", sample_active);
        end
        wait_neg_ci(16);
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_ready_drop: in_ready=%0b after 32 beats, required 0", in_ready);
        end
        wait_neg_ci(0);
        n_cmp++;
        if (sample_active !== 1'b1 || in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_block2: active=%0b ready=%0b, required 1 and 1", sample_active, in_ready);
        end
        wait_neg_ci(0);
        n_cmp++;
        if (sample_active !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_block3: active=%0b, required 1", sample_active);
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_mid_operation();
    $display("[TB] reset mid operation");
    align_to(0);
    send_sample(4, 3, 2, 0, 7);
    in_valid = 1'b1;
    in_data  = make_chunk(4, 7);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || sample_active !== 1'b0 || act0 !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_write: ready=%0b active=%0b, required 0 and 0", in_ready, sample_active);
    end
    in_valid = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_write_release: in_ready=%0b, required 1", in_ready);
    end

    align_to(0);
    send_sample(5, 9, 7, 0, C);
    wait_neg_ci(9);
    n_cmp++;
    if (sample_active !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_play_before: active=%0b, required 1", sample_active);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (act0 !== '0 || ans0 !== 1'b0 || etapos0 !== 4'd0 || sample_active !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_play: ans0=%b eta=%0d active=%0b ready=%0b, required all 0",
               ans0, etapos0, sample_active, in_ready);
    end
    sb.delete();
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_play_release: in_ready=%0b, required 1", in_ready);
    end

    align_to(5);
    send_sample(6, 15, 1, 0, C);
    drain();
  endtask

  task automatic test_source_stalls();
    $display("[TB] source stalls");
    step();
    send_sample(7, 2, 5, 50, C);
    send_sample(8, 11, 2, 50, C);
    send_sample(10, 0, 15, 50, C);
    drain();
  endtask

  initial begin : main
    test_reset();
    test_single_sample();
    test_underrun();
    test_boundary_race();
    test_back_to_back();
    test_reset_mid_operation();
    test_source_stalls();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
